// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - instruction fetch stage with a direct-mapped instruction buffer
package gpu_pkg;
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;
endpackage

module fetcher_icache #(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int CACHE_LINES       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  gpu_pkg::core_state_t         core_state,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  input  logic                         invalidate,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output logic [1:0]                   fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction
);
  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = PROGRAM_ADDR_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCHING = 2'd1,
    S_FETCHED  = 2'd2
  } fetch_state_t;

  fetch_state_t state_q, state_d;

  logic [CACHE_LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]          tag_q  [CACHE_LINES];
  logic [PROGRAM_DATA_BITS-1:0] data_q [CACHE_LINES];

  logic [INDEX_BITS-1:0] lookup_idx, fill_idx;
  logic [TAG_BITS-1:0]   lookup_tag, fill_tag;
  logic                  start, hit, fill;

  assign lookup_idx = current_pc[INDEX_BITS-1:0];
  assign lookup_tag = current_pc[PROGRAM_ADDR_BITS-1:INDEX_BITS];
  // Fills index by the registered request address, never the live PC.
  assign fill_idx   = mem_read_address[INDEX_BITS-1:0];
  assign fill_tag   = mem_read_address[PROGRAM_ADDR_BITS-1:INDEX_BITS];

  assign start = enable && (core_state == gpu_pkg::CORE_FETCH);
  assign hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag) && !invalidate;
  assign fill  = (state_q == S_FETCHING) && mem_read_ready;

  assign fetcher_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = hit ? S_FETCHED : S_FETCHING;
      end
      S_FETCHING: begin
        if (mem_read_ready) state_d = S_FETCHED;
      end
      S_FETCHED: begin
        if (core_state == gpu_pkg::CORE_DECODE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      valid_q          <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        if (hit) begin
          instruction <= data_q[lookup_idx];
        end else begin
          mem_read_valid   <= 1'b1;
          mem_read_address <= current_pc;
        end
      end
      if (fill) begin
        mem_read_valid <= 1'b0;
        instruction    <= mem_read_data;
      end
      // Invalidate beats a coincident fill: the word is delivered but not kept.
      if (invalidate) valid_q <= '0;
      else if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_fetcher_icache.sv
// tb/tb_fetcher_icache.sv - directed bench for fetcher_icache
module tb_fetcher_icache;
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  gpu_pkg::core_state_t core_state;
  logic [7:0]           current_pc;
  logic                 invalidate;
  logic                 mem_read_valid;
  logic [7:0]           mem_read_address;
  logic                 mem_read_ready;
  logic [15:0]          mem_read_data;
  logic [1:0]           fetcher_state;
  logic [15:0]          instruction;

  int checks = 0;
  int errors = 0;

  fetcher_icache #(
    .PROGRAM_ADDR_BITS(8),
    .PROGRAM_DATA_BITS(16),
    .CACHE_LINES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .core_state(core_state),
    .current_pc(current_pc),
    .invalidate(invalidate),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] d, input int k);
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = pc;
    tick();
    chk("miss_req_valid", 32'(mem_read_valid), 32'd1);
    chk("miss_req_addr", 32'(mem_read_address), 32'(pc));
    chk("miss_state_fetching", 32'(fetcher_state), 32'd1);
    current_pc = ~pc;
    for (int i = 1; i < k; i++) begin
      tick();
      chk("miss_hold_valid", 32'(mem_read_valid), 32'd1);
      chk("miss_hold_addr", 32'(mem_read_address), 32'(pc));
    end
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    chk("miss_done_valid", 32'(mem_read_valid), 32'd0);
    chk("miss_done_state", 32'(fetcher_state), 32'd2);
    chk("miss_done_instr", 32'(instruction), 32'(d));
    core_state = gpu_pkg::CORE_DECODE;
    tick();
    chk("miss_decode_idle", 32'(fetcher_state), 32'd0);
    chk("miss_decode_instr", 32'(instruction), 32'(d));
  endtask

  task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] d);
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = pc;
    tick();
    chk("hit_state", 32'(fetcher_state), 32'd2);
    chk("hit_no_req", 32'(mem_read_valid), 32'd0);
    chk("hit_instr", 32'(instruction), 32'(d));
    core_state = gpu_pkg::CORE_DECODE;
    tick();
    chk("hit_decode_idle", 32'(fetcher_state), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b1;
    core_state     = gpu_pkg::CORE_IDLE;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    tick();
    tick();
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_state", 32'(fetcher_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a fetch
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = 8'h05;
    tick();
    chk("pre_rst_req", 32'(mem_read_valid), 32'd1);
    core_state = gpu_pkg::CORE_DECODE;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("async_rst_addr", 32'(mem_read_address), 32'd0);
    chk("async_rst_state", 32'(fetcher_state), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5555;
    tick();
    rst_n = 1'b1;
    tick();
    chk("late_ready_state", 32'(fetcher_state), 32'd0);
    chk("late_ready_instr", 32'(instruction), 32'd0);
    mem_read_ready = 1'b0;

    // Cold miss, ready on the third request cycle, then hit
    fetch_miss(8'h05, 16'hA3C1, 3);
    fetch_hit(8'h05, 16'hA3C1);

    // Conflict on index 1
    fetch_miss(8'h09, 16'h1111, 1);
    fetch_hit(8'h09, 16'h1111);
    fetch_miss(8'h05, 16'hA3C1, 1);
    fetch_miss(8'h09, 16'h1111, 2);

    // Invalidate while idle
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    fetch_miss(8'h09, 16'h1111, 1);

    // Invalidate coinciding with a lookup that would hit
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = 8'h09;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    chk("inv_lookup_miss", 32'(fetcher_state), 32'd1);
    chk("inv_lookup_req", 32'(mem_read_valid), 32'd1);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1111;
    tick();
    mem_read_ready = 1'b0;
    core_state = gpu_pkg::CORE_DECODE;
    tick();
    fetch_hit(8'h09, 16'h1111);

    // Invalidate on the fill edge
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = 8'h0D;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h2222;
    invalidate     = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    invalidate     = 1'b0;
    chk("inv_fill_instr", 32'(instruction), 32'h2222);
    chk("inv_fill_state", 32'(fetcher_state), 32'd2);
    core_state = gpu_pkg::CORE_DECODE;
    tick();
    fetch_miss(8'h0D, 16'h2222, 1);

    // Ready outside FETCHING is ignored
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h7777;
    tick();
    chk("idle_ready_instr", 32'(instruction), 32'h2222);
    chk("idle_ready_state", 32'(fetcher_state), 32'd0);
    mem_read_ready = 1'b0;

    // Enable gating
    enable     = 1'b0;
    core_state = gpu_pkg::CORE_FETCH;
    current_pc = 8'h20;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gated_no_req", 32'(mem_read_valid), 32'd0);
      chk("gated_idle", 32'(fetcher_state), 32'd0);
    end
    enable = 1'b1;
    tick();
    chk("ungated_req", 32'(mem_read_valid), 32'd1);
    chk("ungated_addr", 32'(mem_read_address), 32'h20);
    enable = 1'b0;
    tick();
    chk("drop_en_hold", 32'(mem_read_valid), 32'd1);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    chk("drop_en_done_state", 32'(fetcher_state), 32'd2);
    chk("drop_en_done_instr", 32'(instruction), 32'hBEEF);
    chk("drop_en_done_valid", 32'(mem_read_valid), 32'd0);
    core_state = gpu_pkg::CORE_DECODE;
    tick();
    chk("drop_en_idle", 32'(fetcher_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
